muxn_pipe: RTL and testbench

MUXN_PIPE -- requirements
Module: muxn_pipe

---
 rtl/muxn_pipe.sv | 96 +++++++++
 tb/tb_muxn_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muxn_pipe.sv
// One-cycle registered N:1 data multiplexer with stall/flush control.
// Optional sticky out-of-range select flag: define MUXN_SEL_ERR_EN to enable sel_err.
module muxn_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid
`ifdef MUXN_SEL_ERR_EN
  ,
  output logic                    sel_err
`endif
);

  localparam int NUM_SLOTS = 2 ** SEL_W;
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

  // Every select code maps to a slot; unused slots read as zero so no X leaks.
  logic [WIDTH-1:0] lane [NUM_SLOTS];

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : gen_lane
      if (gi < NUM_IN) begin : g_used
        assign lane[gi] = in_bus[gi*WIDTH +: WIDTH];
      end else begin : g_unused
        assign lane[gi] = '0;
      end
    end
  endgenerate

  logic             sel_ok;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             valid_reg, valid_next;

  assign sel_ok = ({1'b0, sel} < NUM_IN_L);

  // flush beats stall, stall beats capture
  always_comb begin
    out_next   = out_reg;
    valid_next = valid_reg;
    if (flush) begin
      valid_next = 1'b0;
    end else if (!stall) begin
      if (in_valid && sel_ok) begin
        out_next   = lane[sel];
        valid_next = 1'b1;
      end else begin
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      out_reg   <= out_next;
      valid_reg <= valid_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = valid_reg;

`ifdef MUXN_SEL_ERR_EN
  logic err_reg, err_next;

  // Only an out-of-range select that would otherwise have been captured counts.
  always_comb begin
    err_next = err_reg;
    if (!flush && !stall && in_valid && !sel_ok) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign sel_err = err_reg;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed bench for muxn_pipe: default 3x32 instance plus a 16x8 select sweep instance.
module tb_muxn_pipe;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel_a;
  logic [95:0] in_bus_a;
  logic        in_valid_a, stall_a, flush_a;
  logic [31:0] out_a;
  logic        out_valid_a;
`ifdef MUXN_SEL_ERR_EN
  logic        sel_err_a;
  logic        sel_err_b;
`endif

  logic [3:0]   sel_b;
  logic [127:0] in_bus_b;
  logic         in_valid_b;
  logic [7:0]   out_b;
  logic         out_valid_b;

  int vec_cnt;
  int err_cnt;

  muxn_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel_a),
    .in_bus    (in_bus_a),
    .in_valid  (in_valid_a),
    .stall     (stall_a),
    .flush     (flush_a),
    .out       (out_a),
    .out_valid (out_valid_a)
`ifdef MUXN_SEL_ERR_EN
    ,
    .sel_err   (sel_err_a)
`endif
  );

  muxn_pipe #(.WIDTH(8), .NUM_IN(16), .SEL_W(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel_b),
    .in_bus    (in_bus_b),
    .in_valid  (in_valid_b),
    .stall     (1'b0),
    .flush     (1'b0),
    .out       (out_b),
    .out_valid (out_valid_b)
`ifdef MUXN_SEL_ERR_EN
    ,
    .sel_err   (sel_err_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane k of the wide instance carries {k, ~k} so neighbouring lanes differ in every nibble.
  function automatic logic [7:0] lane_b(input int k);
    logic [3:0] kk;
    kk = 4'(k);
    return {kk, ~kk};
  endfunction

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    rst_n      = 1'b0;
    sel_a      = '0;
    in_bus_a   = '0;
    in_valid_a = 1'b0;
    stall_a    = 1'b0;
    flush_a    = 1'b0;
    sel_b      = '0;
    in_valid_b = 1'b0;
    for (int k = 0; k < 16; k++) in_bus_b[k*8 +: 8] = lane_b(k);

    #3;
    chk("reset_out", out_a, 32'h0);
    chk("reset_valid", {31'b0, out_valid_a}, 32'h0);
    chk("reset_b_valid", {31'b0, out_valid_b}, 32'h0);
`ifdef MUXN_SEL_ERR_EN
    chk("reset_sel_err", {31'b0, sel_err_a}, 32'h0);
`endif

    // Release between edges; first capture happens on the next edge.
    step();
    rst_n      = 1'b1;
    in_bus_a   = {32'h3, 32'h2, 32'h1};
    sel_a      = 2'd1;
    in_valid_a = 1'b1;
    step();
    chk("cap_sel1_out", out_a, 32'h2);
    chk("cap_sel1_valid", {31'b0, out_valid_a}, 32'h1);

    stall_a = 1'b1;
    sel_a   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_out", i), out_a, 32'h2);
      chk($sformatf("stall%0d_valid", i), {31'b0, out_valid_a}, 32'h1);
    end
    stall_a = 1'b0;
    step();
    chk("unstall_out", out_a, 32'h1);
    chk("unstall_valid", {31'b0, out_valid_a}, 32'h1);

    in_valid_a = 1'b0;
    step();
    chk("idle_out", out_a, 32'h1);
    chk("idle_valid", {31'b0, out_valid_a}, 32'h0);

    in_valid_a = 1'b1;
    sel_a      = 2'd2;
    step();
    chk("cap_sel2_out", out_a, 32'h3);
    chk("cap_sel2_valid", {31'b0, out_valid_a}, 32'h1);

    stall_a = 1'b1;
    flush_a = 1'b1;
    sel_a   = 2'd0;
    step();
    chk("flush_stall_out", out_a, 32'h3);
    chk("flush_stall_valid", {31'b0, out_valid_a}, 32'h0);

    stall_a = 1'b0;
    step();
    chk("flush_only_out", out_a, 32'h3);
    chk("flush_only_valid", {31'b0, out_valid_a}, 32'h0);

    flush_a = 1'b0;
    sel_a   = 2'd1;
    step();
    chk("recap_out", out_a, 32'h2);
    chk("recap_valid", {31'b0, out_valid_a}, 32'h1);

    // Out-of-range select while stalled is not a transfer attempt.
    stall_a = 1'b1;
    sel_a   = 2'd3;
    step();
    chk("stall_bad_out", out_a, 32'h2);
    chk("stall_bad_valid", {31'b0, out_valid_a}, 32'h1);
`ifdef MUXN_SEL_ERR_EN
    chk("stall_bad_err", {31'b0, sel_err_a}, 32'h0);
`endif

    stall_a = 1'b0;
    step();
    chk("bad_sel_out", out_a, 32'h2);
    chk("bad_sel_valid", {31'b0, out_valid_a}, 32'h0);
`ifdef MUXN_SEL_ERR_EN
    chk("bad_sel_err", {31'b0, sel_err_a}, 32'h1);
`endif

    sel_a = 2'd0;
    step();
    chk("after_bad_out", out_a, 32'h1);
    chk("after_bad_valid", {31'b0, out_valid_a}, 32'h1);
`ifdef MUXN_SEL_ERR_EN
    chk("err_sticky", {31'b0, sel_err_a}, 32'h1);
`endif

    // Bit-exact pass-through of a value with the top bit set.
    in_bus_a = {32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0000};
    sel_a    = 2'd1;
    step();
    chk("bitexact_out", out_a, 32'h8000_0001);

    // Asynchronous reset between edges.
    in_bus_a = {32'h3, 32'h2, 32'h1};
    step();
    chk("pre_rst_out", out_a, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", out_a, 32'h0);
    chk("async_rst_valid", {31'b0, out_valid_a}, 32'h0);
`ifdef MUXN_SEL_ERR_EN
    chk("async_rst_err", {31'b0, sel_err_a}, 32'h0);
`endif

    // Reset during a stall: the stall is forgotten.
    step();
    rst_n = 1'b1;
    sel_a = 2'd2;
    step();
    chk("cap_pre_stall_out", out_a, 32'h3);
    stall_a = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_in_stall_out", out_a, 32'h0);
    chk("rst_in_stall_valid", {31'b0, out_valid_a}, 32'h0);
    step();
    rst_n      = 1'b1;
    stall_a    = 1'b0;
    in_valid_a = 1'b0;
    step();
    chk("post_rst_idle_out", out_a, 32'h0);
    chk("post_rst_idle_valid", {31'b0, out_valid_a}, 32'h0);
    in_valid_a = 1'b1;
    sel_a      = 2'd0;
    step();
    chk("post_rst_cap_out", out_a, 32'h1);

    // Back-to-back sweep of all 16 selects on the wide instance.
    in_valid_b = 1'b1;
    for (int k = 0; k < 16; k++) begin
      sel_b = 4'(k);
      step();
      chk($sformatf("sweep%0d_out", k), {24'b0, out_b}, {24'b0, lane_b(k)});
      chk($sformatf("sweep%0d_valid", k), {31'b0, out_valid_b}, 32'h1);
    end
    in_valid_b = 1'b0;
    step();
    chk("sweep_end_valid", {31'b0, out_valid_b}, 32'h0);
    chk("sweep_end_out", {24'b0, out_b}, {24'b0, lane_b(15)});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
